// File: rtl/instr_fetch_if.sv
// Instruction-read port between the fetch stage (master) and the shared memory port (slave).
interface instr_fetch_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, issues single outstanding reads and hands words to decode.
// Optional stall counter is built when IF_STALL_CNT_EN is defined.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_FETCH | request a read at pc unless execute owns the memory port
//  S_WAIT  | read granted, waiting for rvalid
//  S_HOLD  | instruction presented to decode until instr_ready
//  S_DRAIN | redirect hit an in-flight read; swallow its stale rvalid
module instr_fetch #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_fetch_if.master      mem,
    input  logic               data_busy,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [4:0]         opcode,
    output logic [PC_W-1:0]    instr_pc,
    output logic [PC_W-1:0]    pc_plus2,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [15:0]        stall_cnt
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pc_inc;
    logic            req_c, load_ir, clr_valid;

    assign pc_inc = pc + PC_W'(2);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_c     = 1'b0;
        load_ir   = 1'b0;
        clr_valid = 1'b0;
        case (state)
            S_FETCH: begin
                req_c = !data_busy;
                if (req_c && mem.mem_gnt) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_nxt = S_HOLD;
                    load_ir   = 1'b1;
                    pc_nxt    = pc_inc;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_nxt = S_FETCH;
                    clr_valid = 1'b1;
                end
            end
            S_DRAIN: begin
                if (mem.mem_rvalid) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        // A redirect overrides everything; only a read still in flight forces a drain.
        if (redirect) begin
            load_ir   = 1'b0;
            clr_valid = 1'b1;
            pc_nxt    = {redirect_pc[PC_W-1:1], 1'b0};
            case (state)
                S_FETCH: state_nxt = (req_c && mem.mem_gnt) ? S_DRAIN : S_FETCH;
                S_WAIT,
                S_DRAIN: state_nxt = mem.mem_rvalid ? S_FETCH : S_DRAIN;
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    // Gating with reset_n keeps the request low while reset is asserted.
    assign mem.mem_req  = req_c && reset_n;
    assign mem.mem_addr = pc;
    assign opcode       = instr_out[4:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            pc_plus2    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_ir) begin
                instr_out   <= mem.mem_rdata;
                instr_pc    <= pc;
                pc_plus2    <= pc_inc;
                instr_valid <= 1'b1;
            end else if (clr_valid) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef IF_STALL_CNT_EN
    logic stall_hit;

    assign stall_hit = ((state == S_FETCH) && data_busy) ||
                       ((state == S_HOLD) && !instr_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall_hit && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responder plus a scoreboard of expected decode-side words.
module tb_instr_fetch;

    localparam int STALL_EN =
`ifdef IF_STALL_CNT_EN
        1;
`else
        0;
`endif

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        data_busy;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic [4:0]  opcode;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus2;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] stall_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_pc;
    exp_t        sb_q[$];

    instr_fetch_if #(.PC_W(16), .INSTR_W(16)) mbus ();

    instr_fetch #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem         (mbus),
        .data_busy   (data_busy),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .pc_plus2    (pc_plus2),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        #1;
        while (!mbus.mem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", 32'(mbus.mem_req), 32'd1);
        check("req_addr", 32'(mbus.mem_addr), 32'(exp_pc));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"},   32'(mbus.mem_req),  32'd0);
        check({tag, "_addr"},  32'(mbus.mem_addr), 32'h0000);
        check({tag, "_valid"}, 32'(instr_valid),   32'd0);
        check({tag, "_instr"}, 32'(instr_out),     32'd0);
        check({tag, "_op"},    32'(opcode),        32'd0);
        check({tag, "_ipc"},   32'(instr_pc),      32'd0);
        check({tag, "_pc2"},   32'(pc_plus2),      32'd0);
        check({tag, "_stall"}, 32'(stall_cnt),     32'd0);
    endtask

    // Grant a read at exp_pc, return data k cycles later and score the presented instruction.
    task automatic do_fetch(input logic [15:0] data, input int k);
        exp_t e;
        wait_req();
        mbus.mem_gnt = 1'b1;
        sb_q.push_back({data, exp_pc, exp_pc + 16'd2});
        tick();
        mbus.mem_gnt = 1'b0;
        for (int i = 1; i < k; i++) tick();
        check("wait_req_low", 32'(mbus.mem_req), 32'd0);
        check("wait_no_valid", 32'(instr_valid), 32'd0);
        mbus.mem_rvalid = 1'b1;
        mbus.mem_rdata  = data;
        tick();
        mbus.mem_rvalid = 1'b0;
        mbus.mem_rdata  = 16'h0000;
        check("valid", 32'(instr_valid), 32'd1);
        e = sb_q.pop_front();
        check("instr_out", 32'(instr_out), 32'(e.instr));
        check("opcode",    32'(opcode),    32'(e.instr[4:0]));
        check("instr_pc",  32'(instr_pc),  32'(e.pc));
        check("pc_plus2",  32'(pc_plus2),  32'(e.pc2));
        exp_pc = exp_pc + 16'd2;
    endtask

    initial begin
        reset_n         = 1'b0;
        data_busy       = 1'b0;
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 16'h0000;
        mbus.mem_gnt    = 1'b0;
        mbus.mem_rvalid = 1'b0;
        mbus.mem_rdata  = 16'h0000;
        exp_pc          = 16'h0000;
        #1;
        check_zero("rst");
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // basic fetch, ready held high
        instr_ready = 1'b1;
        do_fetch(16'h1234, 1);
        tick();
        check("t1_consumed", 32'(instr_valid), 32'd0);
        check("t1_next_req", 32'(mbus.mem_req), 32'd1);
        check("t1_next_addr", 32'(mbus.mem_addr), 32'h0002);

        // decode back-pressure in HOLD
        instr_ready = 1'b0;
        do_fetch(16'hABCD, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", 32'(instr_out), 32'hABCD);
            check("hold_req", 32'(mbus.mem_req), 32'd0);
        end
        check("stall_hold", 32'(stall_cnt), STALL_EN ? 32'd5 : 32'd0);
        instr_ready = 1'b1;
        tick();
        check("t2_consumed", 32'(instr_valid), 32'd0);

        // execute owns the port for 3 cycles
        data_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("busy_req", 32'(mbus.mem_req), 32'd0);
            tick();
        end
        data_busy = 1'b0;
        do_fetch(16'h00C5, 1);
        check("stall_busy", 32'(stall_cnt), STALL_EN ? 32'd8 : 32'd0);

        // redirect while WAIT -> drain the stale read
        wait_req();
        mbus.mem_gnt = 1'b1;
        tick();
        mbus.mem_gnt = 1'b0;
        redirect     = 1'b1;
        redirect_pc  = 16'h0041;
        tick();
        redirect = 1'b0;
        check("drain_req", 32'(mbus.mem_req), 32'd0);
        check("drain_addr", 32'(mbus.mem_addr), 32'h0040);
        check("drain_valid", 32'(instr_valid), 32'd0);
        tick();
        check("drain_hold_req", 32'(mbus.mem_req), 32'd0);
        mbus.mem_rvalid = 1'b1;
        mbus.mem_rdata  = 16'hDEAD;
        tick();
        mbus.mem_rvalid = 1'b0;
        check("stale_valid", 32'(instr_valid), 32'd0);
        check("stale_instr", 32'(instr_out), 32'h00C5);
        exp_pc = 16'h0040;
        do_fetch(16'h5A5A, 3);

        // redirect in FETCH without grant, then wrap at top of memory
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        exp_pc   = 16'hFFFE;
        do_fetch(16'h0F0F, 1);
        tick();
        check("wrap_addr", 32'(mbus.mem_addr), 32'h0000);
        check("wrap_req", 32'(mbus.mem_req), 32'd1);

        // redirect beats instr_ready in HOLD
        instr_ready = 1'b0;
        do_fetch(16'h7777, 1);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        check("rdhold_valid", 32'(instr_valid), 32'd0);
        check("rdhold_addr", 32'(mbus.mem_addr), 32'h0100);
        exp_pc = 16'h0100;

        // redirect with rvalid in WAIT -> straight to FETCH
        wait_req();
        mbus.mem_gnt = 1'b1;
        tick();
        mbus.mem_gnt    = 1'b0;
        redirect        = 1'b1;
        redirect_pc     = 16'h0200;
        mbus.mem_rvalid = 1'b1;
        mbus.mem_rdata  = 16'hBEEF;
        tick();
        redirect        = 1'b0;
        mbus.mem_rvalid = 1'b0;
        check("rdrv_valid", 32'(instr_valid), 32'd0);
        check("rdrv_req", 32'(mbus.mem_req), 32'd1);
        check("rdrv_addr", 32'(mbus.mem_addr), 32'h0200);
        check("rdrv_instr", 32'(instr_out), 32'h7777);
        exp_pc = 16'h0200;

        // async reset in the middle of WAIT
        wait_req();
        mbus.mem_gnt = 1'b1;
        tick();
        mbus.mem_gnt = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        exp_pc = 16'h0000;
        do_fetch(16'h0013, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
